mem_req_arbiter: RTL

- Requester/initiator side of the 128-bit line RAM interface.
- Accepts line-fill requests from the instruction cache, and line-fill or line-writeback requests from the data cache.
- Arbitrates between the two, drives the RAM's line address, write-address, write-data and write-enable inputs, and models a fixed memory latency.
- Returns the 128-bit line to the requesting cache with a one-cycle ready pulse.
- Sits between the cache miss handlers and ram_memory.

---
 rtl/mem_req_arbiter_if.sv | 42 ++++
 rtl/mem_req_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter_if.sv
// Bus bundle between the cache miss handlers, the line RAM and the arbiter.
// The arbiter uses the slave modport; the caches plus RAM side use master.
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 26,
    parameter int LINE_W = 128
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ready;
    logic [LINE_W-1:0] ic_line;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic              dc_ready;
    logic [LINE_W-1:0] dc_line;

    logic [ADDR_W-1:0] mem_data_requested;
    logic [ADDR_W-1:0] mem_where_to_write;
    logic [LINE_W-1:0] mem_data_to_write;
    logic              mem_write_to_mem;
    logic [LINE_W-1:0] mem_data_returned;

    modport master (
        output ic_req, ic_addr,
        input  ic_ready, ic_line,
        output dc_req, dc_we, dc_addr, dc_wdata,
        input  dc_ready, dc_line,
        input  mem_data_requested, mem_where_to_write, mem_data_to_write, mem_write_to_mem,
        output mem_data_returned
    );

    modport slave (
        input  ic_req, ic_addr,
        output ic_ready, ic_line,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        output dc_ready, dc_line,
        output mem_data_requested, mem_where_to_write, mem_data_to_write, mem_write_to_mem,
        input  mem_data_returned
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Line-RAM requester: arbitrates icache/dcache line requests, holds a single RAM
// transaction for MEM_LATENCY cycles, then returns the line with a one-cycle ready.
module mem_req_arbiter #(
    parameter int MEM_LATENCY = 5,
    parameter int ADDR_W      = 26,
    parameter int LINE_W      = 128
) (
    input  logic             clk,
    input  logic             reset,
    mem_req_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY);
    localparam logic [3:0] CNT_ONE  = 4'd1;

    // Alternating priority on a tie: returns 1 when the dcache wins the grant.
    function automatic logic pick_dc(input logic ic_req_v, input logic dc_req_v,
                                     input logic last_dc_v);
        logic win_v;
        if (ic_req_v && dc_req_v) begin
            win_v = ~last_dc_v;
        end else if (dc_req_v) begin
            win_v = 1'b1;
        end else begin
            win_v = 1'b0;
        end
        return win_v;
    endfunction

    logic [1:0]        state_r;
    logic [3:0]        cnt_r;
    logic              last_dc_r;
    logic              txn_dc_r;
    logic              txn_we_r;
    logic [ADDR_W-1:0] txn_addr_r;
    logic [LINE_W-1:0] txn_wdata_r;

    logic              ic_ready_r;
    logic              dc_ready_r;
    logic [LINE_W-1:0] ic_line_r;
    logic [LINE_W-1:0] dc_line_r;
    logic [ADDR_W-1:0] mem_rd_addr_r;
    logic [ADDR_W-1:0] mem_wr_addr_r;
    logic [LINE_W-1:0] mem_wr_data_r;
    logic              mem_wr_en_r;

    logic              grant_s;
    logic              grant_dc_s;
    logic              done_s;
    logic [1:0]        state_nxt_s;
    logic [3:0]        cnt_nxt_s;
    logic              txn_dc_nxt_s;
    logic              txn_we_nxt_s;
    logic [ADDR_W-1:0] txn_addr_nxt_s;
    logic [LINE_W-1:0] txn_wdata_nxt_s;
    logic              busy_nxt_s;
    logic [ADDR_W-1:0] mem_rd_addr_nxt_s;
    logic [ADDR_W-1:0] mem_wr_addr_nxt_s;
    logic [LINE_W-1:0] mem_wr_data_nxt_s;
    logic              mem_wr_en_nxt_s;
    logic              ic_ready_nxt_s;
    logic              dc_ready_nxt_s;
    logic [LINE_W-1:0] ic_line_nxt_s;
    logic [LINE_W-1:0] dc_line_nxt_s;

    // Request sampling and arbitration; requests are only looked at in IDLE.
    always_comb begin
        grant_s    = 1'b0;
        grant_dc_s = 1'b0;
        if (state_r == ST_IDLE) begin
            grant_s    = bus.ic_req | bus.dc_req;
            grant_dc_s = pick_dc(bus.ic_req, bus.dc_req, last_dc_r);
        end else begin
            grant_s    = 1'b0;
            grant_dc_s = 1'b0;
        end
    end

    // Sequencing IDLE -> BUSY (count 1..MEM_LATENCY) -> RESP -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            ST_BUSY: begin
                if (cnt_r == LAT_LAST) begin
                    state_nxt_s = ST_RESP;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = cnt_r + 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Transaction latch: the client's fields are copied once at grant and never re-read.
    always_comb begin
        txn_dc_nxt_s    = txn_dc_r;
        txn_we_nxt_s    = txn_we_r;
        txn_addr_nxt_s  = txn_addr_r;
        txn_wdata_nxt_s = txn_wdata_r;
        if (grant_s && grant_dc_s) begin
            txn_dc_nxt_s    = 1'b1;
            txn_we_nxt_s    = bus.dc_we;
            txn_addr_nxt_s  = bus.dc_addr;
            txn_wdata_nxt_s = bus.dc_wdata;
        end else if (grant_s) begin
            txn_dc_nxt_s    = 1'b0;
            txn_we_nxt_s    = 1'b0;
            txn_addr_nxt_s  = bus.ic_addr;
            txn_wdata_nxt_s = '0;
        end else begin
            txn_dc_nxt_s    = txn_dc_r;
            txn_we_nxt_s    = txn_we_r;
            txn_addr_nxt_s  = txn_addr_r;
            txn_wdata_nxt_s = txn_wdata_r;
        end
    end

    // RAM-side outputs are computed for the next cycle so they leave a register.
    always_comb begin
        busy_nxt_s        = (state_nxt_s == ST_BUSY);
        mem_rd_addr_nxt_s = '0;
        mem_wr_addr_nxt_s = '0;
        mem_wr_data_nxt_s = '0;
        mem_wr_en_nxt_s   = 1'b0;
        if (busy_nxt_s && txn_we_nxt_s) begin
            mem_wr_addr_nxt_s = txn_addr_nxt_s;
            mem_wr_data_nxt_s = txn_wdata_nxt_s;
            mem_wr_en_nxt_s   = (cnt_nxt_s == LAT_LAST);
        end else if (busy_nxt_s) begin
            mem_rd_addr_nxt_s = txn_addr_nxt_s;
        end else begin
            mem_rd_addr_nxt_s = '0;
        end
    end

    // Completion: on the last BUSY cycle the read data is captured and ready is armed.
    always_comb begin
        done_s         = (state_r == ST_BUSY) && (cnt_r == LAT_LAST);
        ic_ready_nxt_s = 1'b0;
        dc_ready_nxt_s = 1'b0;
        ic_line_nxt_s  = ic_line_r;
        dc_line_nxt_s  = dc_line_r;
        if (done_s && txn_dc_r) begin
            dc_ready_nxt_s = 1'b1;
            if (!txn_we_r) begin
                dc_line_nxt_s = bus.mem_data_returned;
            end else begin
                dc_line_nxt_s = dc_line_r;
            end
        end else if (done_s) begin
            ic_ready_nxt_s = 1'b1;
            ic_line_nxt_s  = bus.mem_data_returned;
        end else begin
            ic_ready_nxt_s = 1'b0;
            dc_ready_nxt_s = 1'b0;
        end
    end

    // State, transaction and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            last_dc_r     <= 1'b0;
            txn_dc_r      <= 1'b0;
            txn_we_r      <= 1'b0;
            txn_addr_r    <= '0;
            txn_wdata_r   <= '0;
            ic_ready_r    <= 1'b0;
            dc_ready_r    <= 1'b0;
            ic_line_r     <= '0;
            dc_line_r     <= '0;
            mem_rd_addr_r <= '0;
            mem_wr_addr_r <= '0;
            mem_wr_data_r <= '0;
            mem_wr_en_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            last_dc_r     <= grant_s ? grant_dc_s : last_dc_r;
            txn_dc_r      <= txn_dc_nxt_s;
            txn_we_r      <= txn_we_nxt_s;
            txn_addr_r    <= txn_addr_nxt_s;
            txn_wdata_r   <= txn_wdata_nxt_s;
            ic_ready_r    <= ic_ready_nxt_s;
            dc_ready_r    <= dc_ready_nxt_s;
            ic_line_r     <= ic_line_nxt_s;
            dc_line_r     <= dc_line_nxt_s;
            mem_rd_addr_r <= mem_rd_addr_nxt_s;
            mem_wr_addr_r <= mem_wr_addr_nxt_s;
            mem_wr_data_r <= mem_wr_data_nxt_s;
            mem_wr_en_r   <= mem_wr_en_nxt_s;
        end
    end

    assign bus.ic_ready           = ic_ready_r;
    assign bus.dc_ready           = dc_ready_r;
    assign bus.ic_line            = ic_line_r;
    assign bus.dc_line            = dc_line_r;
    assign bus.mem_data_requested = mem_rd_addr_r;
    assign bus.mem_where_to_write = mem_wr_addr_r;
    assign bus.mem_data_to_write  = mem_wr_data_r;
    assign bus.mem_write_to_mem   = mem_wr_en_r;

endmodule
